// File: rtl/cache_miss_control.sv
// ----------------------------------------------------------------------------
// cache_miss_control
// Control stage for a 4-way, 8-set, 32-byte-line cache. It sits directly after
// the pipelined metadata/data stage and reads that stage's hit, valid, dirty
// and PLRU outputs. It drives the array load strobes, the data mux selects and
// the pmem address select. It sequences the work for each request: a hit is
// served in the same cycle; a miss writes back a dirty victim, fills the line
// and installs it. It also keeps saturating hit/miss/writeback counters.
//
// Ports
//   i_clk, i_rst           clock, synchronous active-high reset
//   i_mem_read/write       CPU request, held with its address until o_mem_resp
//   o_mem_resp             one-cycle completion pulse
//   i_way_hit/valid/dirty  per-way metadata at the current index
//   i_lru_in               PLRU tree bits at the current index
//   o_v/d/tag_load         per-way array load strobes
//   o_v_datain/d_datain    value written into the valid / dirty arrays
//   o_lru_load/datain      PLRU array write strobe and new bits
//   o_mbr_load             memory buffer register load
//   o_write_en_sel         per-way data write-enable select
//   o_datain_sel           per-way data-in select
//   o_dataout_sel          way selected on the data/tag dataout muxes
//   o_pmem_address_sel     selects the line address for a read or a write-back
//   o_pmem_read/write      line transfer request, held until i_pmem_resp
//   i_pmem_resp            one-cycle transfer-done pulse
//   o_hit/miss/wb_cnt      saturating performance counters
// ----------------------------------------------------------------------------
package cache_miss_control_pkg;
  typedef enum logic [1:0] {
    no_write        = 2'b00,
    cpu_write_cache = 2'b01,
    mem_write_cache = 2'b10
  } dataarraymux_sel_t;

  typedef enum logic {
    cache_read_mem  = 1'b0,
    cache_write_mem = 1'b1
  } pmemaddressmux_sel_t;
endpackage

module cache_miss_control
  import cache_miss_control_pkg::*;
#(
  parameter int num_ways = 4,
  parameter int s_cnt    = 16
) (
  input  logic                          i_clk,
  input  logic                          i_rst,
  input  logic                          i_mem_read,
  input  logic                          i_mem_write,
  output logic                          o_mem_resp,
  input  logic [num_ways-1:0]           i_way_hit,
  input  logic [num_ways-1:0]           i_valid,
  input  logic [num_ways-1:0]           i_dirty,
  input  logic [2:0]                    i_lru_in,
  output logic [num_ways-1:0]           o_v_load,
  output logic [num_ways-1:0]           o_d_load,
  output logic [num_ways-1:0]           o_tag_load,
  output logic                          o_v_datain,
  output logic                          o_d_datain,
  output logic                          o_lru_load,
  output logic [2:0]                    o_lru_datain,
  output logic                          o_mbr_load,
  output dataarraymux_sel_t [3:0]       o_write_en_sel,
  output dataarraymux_sel_t [3:0]       o_datain_sel,
  output logic [1:0]                    o_dataout_sel,
  output pmemaddressmux_sel_t           o_pmem_address_sel,
  output logic                          o_pmem_read,
  output logic                          o_pmem_write,
  input  logic                          i_pmem_resp,
  output logic [s_cnt-1:0]              o_hit_cnt,
  output logic [s_cnt-1:0]              o_miss_cnt,
  output logic [s_cnt-1:0]              o_wb_cnt
);

  typedef enum logic [1:0] {
    S_CHECK   = 2'd0,
    S_WB      = 2'd1,
    S_FILL    = 2'd2,
    S_INSTALL = 2'd3
  } state_t;

  state_t           r_state;
  logic [1:0]       r_victim;
  logic [s_cnt-1:0] r_hit_cnt;
  logic [s_cnt-1:0] r_miss_cnt;
  logic [s_cnt-1:0] r_wb_cnt;

  logic       w_req;
  logic       w_hit;
  logic [1:0] w_hit_way;
  logic [1:0] w_victim;
  logic [2:0] w_lru_next;

  // Index of the lowest set bit; a caller only uses it when some bit is set.
  function automatic logic [1:0] lowest_set(input logic [3:0] v);
    if (v[0]) begin
      return 2'd0;
    end else if (v[1]) begin
      return 2'd1;
    end else if (v[2]) begin
      return 2'd2;
    end else begin
      return 2'd3;
    end
  endfunction

  function automatic logic [3:0] way_onehot(input logic [1:0] w);
    return 4'b0001 << w;
  endfunction

  // Counts up but stops at all-ones instead of wrapping.
  function automatic logic [s_cnt-1:0] sat_inc(input logic [s_cnt-1:0] v);
    if (v == {s_cnt{1'b1}}) begin
      return v;
    end else begin
      return v + {{(s_cnt-1){1'b0}}, 1'b1};
    end
  endfunction

  assign w_req     = i_mem_read | i_mem_write;
  assign w_hit     = |i_way_hit;
  assign w_hit_way = lowest_set(i_way_hit);

  // Victim choice: an empty way is used first; if all ways are full, the PLRU tree picks.
  always_comb begin
    w_victim = 2'd0;
    if (!(&i_valid)) begin
      w_victim = lowest_set(~i_valid);
    end else if (i_lru_in[2] == 1'b0) begin
      w_victim = i_lru_in[0] ? 2'd2 : 2'd3;
    end else begin
      w_victim = i_lru_in[1] ? 2'd0 : 2'd1;
    end
  end

  // PLRU update for the hit way. The bits on the other subtree are left unchanged.
  always_comb begin
    w_lru_next = i_lru_in;
    case (w_hit_way)
      2'd0: begin w_lru_next[2] = 1'b0; w_lru_next[1] = 1'b0; end
      2'd1: begin w_lru_next[2] = 1'b0; w_lru_next[1] = 1'b1; end
      2'd2: begin w_lru_next[2] = 1'b1; w_lru_next[0] = 1'b0; end
      2'd3: begin w_lru_next[2] = 1'b1; w_lru_next[0] = 1'b1; end
      default: w_lru_next = i_lru_in;
    endcase
  end

  // Sequencer state, victim latch and performance counters.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state    <= S_CHECK;
      r_victim   <= 2'd0;
      r_hit_cnt  <= {s_cnt{1'b0}};
      r_miss_cnt <= {s_cnt{1'b0}};
      r_wb_cnt   <= {s_cnt{1'b0}};
    end else begin
      case (r_state)
        S_CHECK: begin
          if (w_req && w_hit) begin
            r_hit_cnt <= sat_inc(r_hit_cnt);
          end else if (w_req) begin
            r_victim   <= w_victim;
            r_miss_cnt <= sat_inc(r_miss_cnt);
            r_state    <= (i_valid[w_victim] && i_dirty[w_victim]) ? S_WB : S_FILL;
          end else begin
            r_state <= S_CHECK;
          end
        end
        S_WB: begin
          if (i_pmem_resp) begin
            r_wb_cnt <= sat_inc(r_wb_cnt);
            r_state  <= S_FILL;
          end else begin
            r_state <= S_WB;
          end
        end
        S_FILL: begin
          r_state <= i_pmem_resp ? S_INSTALL : S_FILL;
        end
        S_INSTALL: begin
          r_state <= S_CHECK;
        end
        default: begin
          r_state <= S_CHECK;
        end
      endcase
    end
  end

  assign o_hit_cnt  = r_hit_cnt;
  assign o_miss_cnt = r_miss_cnt;
  assign o_wb_cnt   = r_wb_cnt;

  // Array and pmem controls. These are combinational because a hit must respond
  // in the same cycle. They are forced idle while reset is high.
  always_comb begin
    o_mem_resp         = 1'b0;
    o_v_load           = 4'b0000;
    o_d_load           = 4'b0000;
    o_tag_load         = 4'b0000;
    o_v_datain         = 1'b0;
    o_d_datain         = 1'b0;
    o_lru_load         = 1'b0;
    o_lru_datain       = 3'b000;
    o_mbr_load         = 1'b0;
    o_dataout_sel      = 2'd0;
    o_pmem_address_sel = cache_read_mem;
    o_pmem_read        = 1'b0;
    o_pmem_write       = 1'b0;
    for (int i = 0; i < 4; i++) begin
      o_write_en_sel[i] = no_write;
      o_datain_sel[i]   = no_write;
    end
    if (i_rst) begin
      o_mem_resp = 1'b0;
    end else begin
      case (r_state)
        S_CHECK: begin
          if (w_req && w_hit) begin
            o_mem_resp    = 1'b1;
            o_lru_load    = 1'b1;
            o_lru_datain  = w_lru_next;
            o_dataout_sel = w_hit_way;
            // A write takes priority when read and write are both asserted.
            if (i_mem_write) begin
              o_write_en_sel[w_hit_way] = cpu_write_cache;
              o_datain_sel[w_hit_way]   = cpu_write_cache;
              o_d_load                  = way_onehot(w_hit_way);
              o_d_datain                = 1'b1;
            end else begin
              o_d_datain = 1'b0;
            end
          end else begin
            o_mem_resp = 1'b0;
          end
        end
        S_WB: begin
          o_pmem_write       = 1'b1;
          o_pmem_address_sel = cache_write_mem;
          o_dataout_sel      = r_victim;
        end
        S_FILL: begin
          o_pmem_read        = 1'b1;
          o_pmem_address_sel = cache_read_mem;
          o_mbr_load         = i_pmem_resp;
        end
        S_INSTALL: begin
          o_write_en_sel[r_victim] = mem_write_cache;
          o_datain_sel[r_victim]   = mem_write_cache;
          o_tag_load               = way_onehot(r_victim);
          o_v_load                 = way_onehot(r_victim);
          o_d_load                 = way_onehot(r_victim);
          o_v_datain               = 1'b1;
          o_d_datain               = 1'b0;
        end
        default: begin
          o_mem_resp = 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cache_miss_control.sv
module tb_cache_miss_control;
  import cache_miss_control_pkg::*;

  localparam int SC = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          mem_read, mem_write, pmem_resp;
  logic [3:0]    way_hit, valid, dirty;
  logic [2:0]    lru_in;
  logic          mem_resp, v_datain, d_datain, lru_load, mbr_load;
  logic          pmem_read, pmem_write, pmem_address_sel;
  logic [3:0]    v_load, d_load, tag_load;
  logic [2:0]    lru_datain;
  logic [7:0]    write_en_sel, datain_sel;
  logic [1:0]    dataout_sel;
  logic [SC-1:0] hit_cnt, miss_cnt, wb_cnt;

  int tests = 0;
  int fails = 0;

  cache_miss_control #(.num_ways(4), .s_cnt(SC)) dut (
    .i_clk(clk), .i_rst(rst), .i_mem_read(mem_read), .i_mem_write(mem_write),
    .o_mem_resp(mem_resp), .i_way_hit(way_hit), .i_valid(valid), .i_dirty(dirty),
    .i_lru_in(lru_in), .o_v_load(v_load), .o_d_load(d_load), .o_tag_load(tag_load),
    .o_v_datain(v_datain), .o_d_datain(d_datain), .o_lru_load(lru_load),
    .o_lru_datain(lru_datain), .o_mbr_load(mbr_load), .o_write_en_sel(write_en_sel),
    .o_datain_sel(datain_sel), .o_dataout_sel(dataout_sel),
    .o_pmem_address_sel(pmem_address_sel), .o_pmem_read(pmem_read),
    .o_pmem_write(pmem_write), .i_pmem_resp(pmem_resp), .o_hit_cnt(hit_cnt),
    .o_miss_cnt(miss_cnt), .o_wb_cnt(wb_cnt)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_req();
    mem_read = 1'b0; mem_write = 1'b0; way_hit = 4'b0000;
  endtask

  task automatic test_reset();
    rst = 1'b1; idle_req(); pmem_resp = 1'b0;
    valid = 4'b0000; dirty = 4'b0000; lru_in = 3'b000;
    tick(); tick();
    mem_read = 1'b1; way_hit = 4'b0001; #1;
    tests++; if (mem_resp !== 1'b0) begin fails++; $display("FAIL rst_resp_gated got %0b exp 0", mem_resp); end
    idle_req(); rst = 1'b0;
    tick();
    tests++; if (hit_cnt !== 8'd0 || miss_cnt !== 8'd0 || wb_cnt !== 8'd0) begin fails++; $display("FAIL rst_counters got %0d/%0d/%0d exp 0/0/0", hit_cnt, miss_cnt, wb_cnt); end
    tests++; if (write_en_sel !== {4{no_write}} || datain_sel !== {4{no_write}}) begin fails++; $display("FAIL rst_sels got %h/%h exp 00/00", write_en_sel, datain_sel); end
    tests++; if (pmem_read !== 1'b0 || pmem_write !== 1'b0 || pmem_address_sel !== cache_read_mem || dataout_sel !== 2'd0) begin fails++; $display("FAIL rst_pmem got r%0b w%0b a%0b d%0d exp r0 w0 a0 d0", pmem_read, pmem_write, pmem_address_sel, dataout_sel); end
    tests++; if (v_load !== 4'b0 || d_load !== 4'b0 || tag_load !== 4'b0 || lru_load !== 1'b0 || mbr_load !== 1'b0 || mem_resp !== 1'b0) begin fails++; $display("FAIL rst_loads got v%b d%b t%b l%b m%b r%b exp all 0", v_load, d_load, tag_load, lru_load, mbr_load, mem_resp); end
  endtask

  task automatic test_read_hit();
    mem_read = 1'b1; way_hit = 4'b0100; valid = 4'hF; lru_in = 3'b000; #1;
    tests++; if (mem_resp !== 1'b1 || lru_load !== 1'b1) begin fails++; $display("FAIL rh_resp got resp%b lru_load%b exp 1 1", mem_resp, lru_load); end
    tests++; if (dataout_sel !== 2'd2) begin fails++; $display("FAIL rh_dataout got %0d exp 2", dataout_sel); end
    tests++; if (lru_datain !== 3'b100) begin fails++; $display("FAIL rh_lru got %b exp 100", lru_datain); end
    tests++; if (d_load !== 4'b0000 || write_en_sel !== {4{no_write}}) begin fails++; $display("FAIL rh_nowrite got d%b we%h exp 0000 00", d_load, write_en_sel); end
    tick(); idle_req();
    tests++; if (hit_cnt !== 8'd1) begin fails++; $display("FAIL rh_hit_cnt got %0d exp 1", hit_cnt); end
  endtask

  task automatic test_read_miss_fill();
    mem_read = 1'b1; way_hit = 4'b0000; valid = 4'b0011; dirty = 4'b0000; lru_in = 3'b000; #1;
    tests++; if (mem_resp !== 1'b0 || pmem_read !== 1'b0) begin fails++; $display("FAIL rm_check got resp%b pr%b exp 0 0", mem_resp, pmem_read); end
    tick();
    tests++; if (pmem_read !== 1'b1 || pmem_write !== 1'b0 || pmem_address_sel !== cache_read_mem || mbr_load !== 1'b0) begin fails++; $display("FAIL rm_fill got pr%b pw%b a%b mbr%b exp 1 0 0 0", pmem_read, pmem_write, pmem_address_sel, mbr_load); end
    tests++; if (miss_cnt !== 8'd1) begin fails++; $display("FAIL rm_miss_cnt got %0d exp 1", miss_cnt); end
    tick();
    tests++; if (pmem_read !== 1'b1) begin fails++; $display("FAIL rm_fill_hold got %b exp 1", pmem_read); end
    pmem_resp = 1'b1; #1;
    tests++; if (mbr_load !== 1'b1) begin fails++; $display("FAIL rm_mbr got %b exp 1", mbr_load); end
    tick(); pmem_resp = 1'b0; #1;
    tests++; if (tag_load !== 4'b0100 || v_load !== 4'b0100 || d_load !== 4'b0100) begin fails++; $display("FAIL rm_install_loads got t%b v%b d%b exp 0100", tag_load, v_load, d_load); end
    tests++; if (v_datain !== 1'b1 || d_datain !== 1'b0 || pmem_read !== 1'b0 || mem_resp !== 1'b0) begin fails++; $display("FAIL rm_install_vals got v%b d%b pr%b r%b exp 1 0 0 0", v_datain, d_datain, pmem_read, mem_resp); end
    tests++; if (write_en_sel !== {no_write, mem_write_cache, no_write, no_write} || datain_sel !== {no_write, mem_write_cache, no_write, no_write}) begin fails++; $display("FAIL rm_install_sels got %h/%h exp 20/20", write_en_sel, datain_sel); end
    way_hit = 4'b0100; valid = 4'b0111;
    tick();
    tests++; if (mem_resp !== 1'b1 || dataout_sel !== 2'd2) begin fails++; $display("FAIL rm_rehit got resp%b sel%0d exp 1 2", mem_resp, dataout_sel); end
    tick(); idle_req();
    tests++; if (hit_cnt !== 8'd2 || miss_cnt !== 8'd1) begin fails++; $display("FAIL rm_counts got h%0d m%0d exp 2 1", hit_cnt, miss_cnt); end
  endtask

  task automatic test_write_miss_dirty();
    mem_write = 1'b1; way_hit = 4'b0000; valid = 4'hF; dirty = 4'h8; lru_in = 3'b000; #1;
    tick();
    tests++; if (pmem_write !== 1'b1 || pmem_read !== 1'b0 || pmem_address_sel !== cache_write_mem || dataout_sel !== 2'd3) begin fails++; $display("FAIL wm_wb got pw%b pr%b a%b sel%0d exp 1 0 1 3", pmem_write, pmem_read, pmem_address_sel, dataout_sel); end
    tests++; if (miss_cnt !== 8'd2 || wb_cnt !== 8'd0) begin fails++; $display("FAIL wm_cnt_wb got m%0d w%0d exp 2 0", miss_cnt, wb_cnt); end
    pmem_resp = 1'b1;
    tick(); pmem_resp = 1'b0; #1;
    tests++; if (wb_cnt !== 8'd1 || pmem_read !== 1'b1 || pmem_write !== 1'b0 || pmem_address_sel !== cache_read_mem) begin fails++; $display("FAIL wm_fill got wb%0d pr%b pw%b a%b exp 1 1 0 0", wb_cnt, pmem_read, pmem_write, pmem_address_sel); end
    pmem_resp = 1'b1;
    tick(); pmem_resp = 1'b0; #1;
    tests++; if (tag_load !== 4'b1000 || d_load !== 4'b1000 || d_datain !== 1'b0 || write_en_sel !== {mem_write_cache, no_write, no_write, no_write}) begin fails++; $display("FAIL wm_install got t%b d%b dd%b we%h exp 1000 1000 0 80", tag_load, d_load, d_datain, write_en_sel); end
    way_hit = 4'b1000; dirty = 4'h0;
    tick();
    tests++; if (mem_resp !== 1'b1 || d_load !== 4'b1000 || d_datain !== 1'b1) begin fails++; $display("FAIL wm_rehit got r%b d%b dd%b exp 1 1000 1", mem_resp, d_load, d_datain); end
    tests++; if (write_en_sel !== {cpu_write_cache, no_write, no_write, no_write} || lru_datain !== 3'b101) begin fails++; $display("FAIL wm_rehit_sel got we%h lru%b exp 40 101", write_en_sel, lru_datain); end
    tick(); idle_req();
    tests++; if (hit_cnt !== 8'd3) begin fails++; $display("FAIL wm_hit_cnt got %0d exp 3", hit_cnt); end
  endtask

  task automatic test_write_hit();
    mem_read = 1'b1; mem_write = 1'b1; way_hit = 4'b0010; lru_in = 3'b101; #1;
    tests++; if (write_en_sel !== {no_write, no_write, cpu_write_cache, no_write} || datain_sel !== {no_write, no_write, cpu_write_cache, no_write}) begin fails++; $display("FAIL wh_sels got %h/%h exp 04/04", write_en_sel, datain_sel); end
    tests++; if (d_load !== 4'b0010 || d_datain !== 1'b1 || dataout_sel !== 2'd1) begin fails++; $display("FAIL wh_dirty got d%b dd%b sel%0d exp 0010 1 1", d_load, d_datain, dataout_sel); end
    tests++; if (lru_datain !== 3'b011) begin fails++; $display("FAIL wh_lru got %b exp 011", lru_datain); end
    tick(); idle_req();
    tests++; if (hit_cnt !== 8'd4) begin fails++; $display("FAIL wh_hit_cnt got %0d exp 4", hit_cnt); end
  endtask

  task automatic test_back_to_back();
    mem_read = 1'b1; way_hit = 4'b1010; lru_in = 3'b000; #1;
    tests++; if (dataout_sel !== 2'd1 || lru_datain !== 3'b010 || d_load !== 4'b0000) begin fails++; $display("FAIL bb_first got sel%0d lru%b d%b exp 1 010 0000", dataout_sel, lru_datain, d_load); end
    tick();
    way_hit = 4'b0001; lru_in = 3'b111; #1;
    tests++; if (mem_resp !== 1'b1 || dataout_sel !== 2'd0 || lru_datain !== 3'b001) begin fails++; $display("FAIL bb_second got r%b sel%0d lru%b exp 1 0 001", mem_resp, dataout_sel, lru_datain); end
    tick(); idle_req();
    tests++; if (hit_cnt !== 8'd6) begin fails++; $display("FAIL bb_hit_cnt got %0d exp 6", hit_cnt); end
  endtask

  task automatic test_drop_during_wb();
    mem_read = 1'b1; way_hit = 4'b0000; valid = 4'hF; dirty = 4'hF; lru_in = 3'b100; #1;
    tick();
    tests++; if (pmem_write !== 1'b1 || dataout_sel !== 2'd1 || miss_cnt !== 8'd3) begin fails++; $display("FAIL dr_wb got pw%b sel%0d m%0d exp 1 1 3", pmem_write, dataout_sel, miss_cnt); end
    idle_req();
    tick();
    tests++; if (pmem_write !== 1'b1) begin fails++; $display("FAIL dr_wb_hold got %b exp 1", pmem_write); end
    pmem_resp = 1'b1;
    tick(); pmem_resp = 1'b0; #1;
    tests++; if (wb_cnt !== 8'd2 || pmem_read !== 1'b1) begin fails++; $display("FAIL dr_fill got wb%0d pr%b exp 2 1", wb_cnt, pmem_read); end
    pmem_resp = 1'b1;
    tick(); pmem_resp = 1'b0; #1;
    tests++; if (tag_load !== 4'b0010 || v_load !== 4'b0010) begin fails++; $display("FAIL dr_install got t%b v%b exp 0010 0010", tag_load, v_load); end
    tick();
    tests++; if (mem_resp !== 1'b0 || pmem_read !== 1'b0 || hit_cnt !== 8'd6) begin fails++; $display("FAIL dr_idle got r%b pr%b h%0d exp 0 0 6", mem_resp, pmem_read, hit_cnt); end
  endtask

  task automatic test_reset_mid_fill();
    mem_read = 1'b1; way_hit = 4'b0000; valid = 4'b0001; dirty = 4'b0000; lru_in = 3'b000; #1;
    tick(); tick();
    tests++; if (pmem_read !== 1'b1) begin fails++; $display("FAIL rf_in_fill got %b exp 1", pmem_read); end
    rst = 1'b1;
    tick();
    rst = 1'b0; idle_req(); #1;
    tests++; if (pmem_read !== 1'b0 || pmem_write !== 1'b0) begin fails++; $display("FAIL rf_pmem got pr%b pw%b exp 0 0", pmem_read, pmem_write); end
    tests++; if (hit_cnt !== 8'd0 || miss_cnt !== 8'd0 || wb_cnt !== 8'd0) begin fails++; $display("FAIL rf_counters got %0d/%0d/%0d exp 0/0/0", hit_cnt, miss_cnt, wb_cnt); end
    mem_read = 1'b1; way_hit = 4'b0001; #1;
    tests++; if (mem_resp !== 1'b1) begin fails++; $display("FAIL rf_check_hit got %b exp 1", mem_resp); end
    tick();
    tests++; if (hit_cnt !== 8'd1) begin fails++; $display("FAIL rf_hit_cnt got %0d exp 1", hit_cnt); end
  endtask

  // One hit has already been counted; 258 more gives 2^8+3 in total.
  task automatic test_saturation();
    for (int i = 0; i < 253; i++) tick();
    tests++; if (hit_cnt !== 8'd254) begin fails++; $display("FAIL sat_pre got %0d exp 254", hit_cnt); end
    for (int i = 0; i < 5; i++) tick();
    tests++; if (hit_cnt !== 8'd255) begin fails++; $display("FAIL sat_hold got %0d exp 255", hit_cnt); end
    tests++; if (mem_resp !== 1'b1 || miss_cnt !== 8'd0) begin fails++; $display("FAIL sat_side got r%b m%0d exp 1 0", mem_resp, miss_cnt); end
    idle_req();
  endtask

  initial begin
    test_reset();
    test_read_hit();
    test_read_miss_fill();
    test_write_miss_dirty();
    test_write_hit();
    test_back_to_back();
    test_drop_during_wb();
    test_reset_mid_fill();
    test_saturation();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
